// File: rtl/ex_operand_stage_if.sv
// Decode, forwarding and EX-output signal bundle for the EX operand stage.
// The slave modport is the stage itself; the master side drives decode and forwarding.
interface ex_operand_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  id_valid;
    logic [4:0]            id_rs1;
    logic [4:0]            id_rs2;
    logic [4:0]            id_rd;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [DATA_WIDTH-1:0] id_pc;
    logic                  id_alu_src_a;
    logic                  id_alu_src_b;
    logic [3:0]            id_alu_ctrl;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic [4:0]            mem_rd;
    logic                  mem_reg_write;
    logic [DATA_WIDTH-1:0] mem_result;
    logic [4:0]            wb_rd;
    logic                  wb_reg_write;
    logic [DATA_WIDTH-1:0] wb_result;
    logic [DATA_WIDTH-1:0] ALUop1;
    logic [DATA_WIDTH-1:0] ALUop2;
    logic [3:0]            ALUctrl;
    logic                  ex_valid;
    logic [4:0]            ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [DATA_WIDTH-1:0] ex_store_data;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic                  stall_id;
    logic [31:0]           stall_count;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_pc, id_alu_src_a, id_alu_src_b,
               id_alu_ctrl, id_reg_write, id_mem_read, flush,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        output ALUop1, ALUop2, ALUctrl, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
               ex_store_data, ex_pc, stall_id, stall_count
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_pc, id_alu_src_a, id_alu_src_b,
               id_alu_ctrl, id_reg_write, id_mem_read, flush,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        input  ALUop1, ALUop2, ALUctrl, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
               ex_store_data, ex_pc, stall_id, stall_count
    );
endinterface

// File: rtl/ex_operand_stage.sv
// EX pipeline register with MEM/WB operand forwarding, load-use stall detection
// and a saturating stall-cycle counter.
module ex_operand_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_operand_stage_if.slave    bus
);

    logic                  r_valid_p1;
    logic [4:0]            r_rs1_p1;
    logic [4:0]            r_rs2_p1;
    logic [4:0]            r_rd_p1;
    logic                  r_use_rs1_p1;
    logic                  r_use_rs2_p1;
    logic [DATA_WIDTH-1:0] r_rs1_data_p1;
    logic [DATA_WIDTH-1:0] r_rs2_data_p1;
    logic [DATA_WIDTH-1:0] r_imm_p1;
    logic [DATA_WIDTH-1:0] r_pc_p1;
    logic                  r_src_a_p1;
    logic                  r_src_b_p1;
    logic [3:0]            r_alu_ctrl_p1;
    logic                  r_reg_write_p1;
    logic                  r_mem_read_p1;
    logic [31:0]           r_stall_count;

    logic                  w_hazard;
    logic                  w_stall_id;
    logic [DATA_WIDTH-1:0] w_fwd_rs1;
    logic [DATA_WIDTH-1:0] w_fwd_rs2;
    logic                  w_unused;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [4:0]            rs,
        input logic [DATA_WIDTH-1:0] reg_val,
        input logic [4:0]            m_rd,
        input logic                  m_we,
        input logic [DATA_WIDTH-1:0] m_val,
        input logic [4:0]            w_rd,
        input logic                  w_we,
        input logic [DATA_WIDTH-1:0] w_val
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs))
            return m_val;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            return w_val;
        else
            return reg_val;
    endfunction

    // The source-use flags travel with the instruction but nothing past EX consumes them.
    assign w_unused = &{1'b0, r_use_rs1_p1, r_use_rs2_p1};

    assign w_hazard = r_valid_p1 && r_mem_read_p1 && (r_rd_p1 != 5'd0) && bus.id_valid &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == r_rd_p1)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == r_rd_p1)));
    assign w_stall_id = w_hazard && !bus.flush;

    // ID -> EX boundary: reset, flush and load-use all insert an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || bus.flush || w_hazard) begin
            r_valid_p1     <= 1'b0;
            r_rs1_p1       <= '0;
            r_rs2_p1       <= '0;
            r_rd_p1        <= '0;
            r_use_rs1_p1   <= 1'b0;
            r_use_rs2_p1   <= 1'b0;
            r_rs1_data_p1  <= '0;
            r_rs2_data_p1  <= '0;
            r_imm_p1       <= '0;
            r_pc_p1        <= '0;
            r_src_a_p1     <= 1'b0;
            r_src_b_p1     <= 1'b0;
            r_alu_ctrl_p1  <= '0;
            r_reg_write_p1 <= 1'b0;
            r_mem_read_p1  <= 1'b0;
        end else begin
            r_valid_p1     <= bus.id_valid;
            r_rs1_p1       <= bus.id_rs1;
            r_rs2_p1       <= bus.id_rs2;
            r_rd_p1        <= bus.id_rd;
            r_use_rs1_p1   <= bus.id_use_rs1;
            r_use_rs2_p1   <= bus.id_use_rs2;
            r_rs1_data_p1  <= bus.id_rs1_data;
            r_rs2_data_p1  <= bus.id_rs2_data;
            r_imm_p1       <= bus.id_imm;
            r_pc_p1        <= bus.id_pc;
            r_src_a_p1     <= bus.id_alu_src_a;
            r_src_b_p1     <= bus.id_alu_src_b;
            r_alu_ctrl_p1  <= bus.id_alu_ctrl;
            r_reg_write_p1 <= bus.id_valid && bus.id_reg_write;
            r_mem_read_p1  <= bus.id_valid && bus.id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_count <= '0;
        else if (w_stall_id)
            r_stall_count <= sat_inc(r_stall_count);
    end

    // EX stage: operand forwarding and ALU operand muxing, zeroed for bubbles.
    assign w_fwd_rs1 = fwd_sel(r_rs1_p1, r_rs1_data_p1, bus.mem_rd, bus.mem_reg_write,
                               bus.mem_result, bus.wb_rd, bus.wb_reg_write, bus.wb_result);
    assign w_fwd_rs2 = fwd_sel(r_rs2_p1, r_rs2_data_p1, bus.mem_rd, bus.mem_reg_write,
                               bus.mem_result, bus.wb_rd, bus.wb_reg_write, bus.wb_result);

    assign bus.ALUop1        = !r_valid_p1 ? '0 : (r_src_a_p1 ? r_pc_p1  : w_fwd_rs1);
    assign bus.ALUop2        = !r_valid_p1 ? '0 : (r_src_b_p1 ? r_imm_p1 : w_fwd_rs2);
    assign bus.ALUctrl       = r_valid_p1 ? r_alu_ctrl_p1 : 4'd0;
    assign bus.ex_store_data = r_valid_p1 ? w_fwd_rs2 : '0;
    assign bus.ex_valid      = r_valid_p1;
    assign bus.ex_rd         = r_rd_p1;
    assign bus.ex_reg_write  = r_reg_write_p1;
    assign bus.ex_mem_read   = r_mem_read_p1;
    assign bus.ex_pc         = r_pc_p1;
    assign bus.stall_id      = w_stall_id;
    assign bus.stall_count   = r_stall_count;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding, operand select, load-use stall,
// flush, counter saturation and reset.
module tb_ex_operand_stage;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_fail;
    int   n_total;

    ex_operand_stage_if #(.DATA_WIDTH(32)) bus ();

    ex_operand_stage #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [3:0] ctrl, input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_use_rs1   = u1;
        bus.id_use_rs2   = u2;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
        bus.id_alu_ctrl  = ctrl;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_alu_src_a = 1'b0;
        bus.id_alu_src_b = 1'b0;
        bus.id_imm       = 32'h0;
        bus.id_pc        = 32'h0;
    endtask

    task automatic fwd(input logic [4:0] mrd, input logic mwe, input logic [31:0] mval,
                       input logic [4:0] wrd, input logic wwe, input logic [31:0] wval);
        bus.mem_rd        = mrd;
        bus.mem_reg_write = mwe;
        bus.mem_result    = mval;
        bus.wb_rd         = wrd;
        bus.wb_reg_write  = wwe;
        bus.wb_result     = wval;
    endtask

    initial begin
        n_pass = 0;
        n_fail = 0;
        n_total = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h55, 32'h66, 4'h7, 1'b1, 1'b1);
        fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        step();
        step();

        // Reset state, with live decode inputs present
        chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_aluop1", bus.ALUop1, 32'd0);
        chk("rst_aluop2", bus.ALUop2, 32'd0);
        chk("rst_aluctrl", {28'd0, bus.ALUctrl}, 32'd0);
        chk("rst_stall_count", bus.stall_count, 32'd0);
        chk("rst_stall_id", {31'd0, bus.stall_id}, 32'd0);
        chk("rst_ex_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
        rst = 1'b0;

        // Basic ADD
        instr(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'd5, 32'd7, 4'b0000, 1'b1, 1'b0);
        step();
        chk("add_aluop1", bus.ALUop1, 32'd5);
        chk("add_aluop2", bus.ALUop2, 32'd7);
        chk("add_aluctrl", {28'd0, bus.ALUctrl}, 32'd0);
        chk("add_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("add_ex_rd", {27'd0, bus.ex_rd}, 32'd5);
        chk("add_reg_write", {31'd0, bus.ex_reg_write}, 32'd1);

        // Forwarding priority on rs1=3, rs2=4 (SUB)
        instr(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 32'h11, 32'h44, 4'b1000, 1'b1, 1'b0);
        step();
        chk("sub_aluctrl", {28'd0, bus.ALUctrl}, 32'h8);
        fwd(5'd3, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB);
        #1;
        chk("fwd_mem_over_wb", bus.ALUop1, 32'hAA);
        chk("fwd_rs2_untouched", bus.ALUop2, 32'h44);
        fwd(5'd3, 1'b0, 32'hAA, 5'd3, 1'b1, 32'hBB);
        #1;
        chk("fwd_wb_only", bus.ALUop1, 32'hBB);
        fwd(5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB);
        #1;
        chk("fwd_rd0_reg", bus.ALUop1, 32'h11);
        fwd(5'd4, 1'b1, 32'hCC, 5'd4, 1'b1, 32'hDD);
        #1;
        chk("fwd_rs2_mem", bus.ALUop2, 32'hCC);
        chk("fwd_store_data", bus.ex_store_data, 32'hCC);

        // x0 source with producers writing x0
        instr(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h22, 32'h33, 4'h0, 1'b1, 1'b0);
        fwd(5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB);
        step();
        chk("x0_rs1_reg", bus.ALUop1, 32'h22);
        chk("x0_rs2_reg", bus.ALUop2, 32'h33);

        // pc / immediate select, forwarding on rs1 must be ignored
        instr(1'b1, 5'd3, 5'd2, 5'd8, 1'b1, 1'b0, 32'h11, 32'h22, 4'h0, 1'b1, 1'b0);
        bus.id_alu_src_a = 1'b1;
        bus.id_alu_src_b = 1'b1;
        bus.id_pc = 32'h100;
        bus.id_imm = 32'hFFFF_FFFC;
        fwd(5'd3, 1'b1, 32'hAA, 5'd0, 1'b0, 32'h0);
        step();
        chk("sel_aluop1_pc", bus.ALUop1, 32'h100);
        chk("sel_aluop2_imm", bus.ALUop2, 32'hFFFF_FFFC);
        chk("sel_ex_pc", bus.ex_pc, 32'h100);
        fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Load-use on rs2
        instr(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'h9, 32'h0, 4'h0, 1'b1, 1'b1);
        step();
        chk("lu_ex_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
        instr(1'b1, 5'd1, 5'd4, 5'd6, 1'b1, 1'b1, 32'h9, 32'h30, 4'h0, 1'b1, 1'b0);
        #1;
        chk("lu_stall_id", {31'd0, bus.stall_id}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("lu_bubble_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("lu_stall_count", bus.stall_count, 32'd1);
        chk("lu_stall_released", {31'd0, bus.stall_id}, 32'd0);
        step();
        chk("lu_dep_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("lu_dep_rd", {27'd0, bus.ex_rd}, 32'd6);
        chk("lu_dep_aluop2", bus.ALUop2, 32'h30);
        chk("lu_count_hold", bus.stall_count, 32'd1);

        // Flush together with a load-use hazard
        instr(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'h9, 32'h0, 4'h0, 1'b1, 1'b1);
        step();
        instr(1'b1, 5'd1, 5'd4, 5'd6, 1'b1, 1'b1, 32'h9, 32'h30, 4'h0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall_id", {31'd0, bus.stall_id}, 32'd0);
        step();
        bus.flush = 1'b0;
        chk("fl_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("fl_stall_count", bus.stall_count, 32'd1);

        // Invalid decode slot must not carry write enables
        instr(1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 32'h5, 32'h6, 4'h3, 1'b1, 1'b1);
        step();
        chk("inv_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("inv_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("inv_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
        chk("inv_aluop1", bus.ALUop1, 32'd0);

        // Saturation: preload the counter just below the top
        force dut.r_stall_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_count;
        instr(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'h9, 32'h0, 4'h0, 1'b1, 1'b1);
        step();
        instr(1'b1, 5'd4, 5'd2, 5'd6, 1'b1, 1'b0, 32'h9, 32'h0, 4'h0, 1'b1, 1'b0);
        step();
        chk("sat_reach_max", bus.stall_count, 32'hFFFF_FFFF);
        step();
        instr(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'h9, 32'h0, 4'h0, 1'b1, 1'b1);
        step();
        instr(1'b1, 5'd4, 5'd2, 5'd6, 1'b1, 1'b0, 32'h9, 32'h0, 4'h0, 1'b1, 1'b0);
        #1;
        chk("sat_stall_id", {31'd0, bus.stall_id}, 32'd1);
        step();
        chk("sat_no_wrap", bus.stall_count, 32'hFFFF_FFFF);

        // Reset mid-hazard with a saturated counter
        step();
        instr(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'h9, 32'h0, 4'h0, 1'b1, 1'b1);
        step();
        instr(1'b1, 5'd4, 5'd2, 5'd6, 1'b1, 1'b0, 32'h9, 32'h0, 4'h0, 1'b1, 1'b0);
        #1;
        chk("mr_stall_before", {31'd0, bus.stall_id}, 32'd1);
        rst = 1'b1;
        step();
        chk("mr_stall_id", {31'd0, bus.stall_id}, 32'd0);
        chk("mr_stall_count", bus.stall_count, 32'd0);
        chk("mr_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("mr_ex_rd", {27'd0, bus.ex_rd}, 32'd0);
        chk("mr_ex_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
        chk("mr_ex_pc", bus.ex_pc, 32'd0);
        chk("mr_store_data", bus.ex_store_data, 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 Decode-side inputs SHALL be as follows. id_valid (1): the decode slot holds an instruction. id_rs1, id_rs2, id_rd (5 each): register indices. id_use_rs1, id_use_rs2 (1 each): the instruction reads that source. id_rs1_data, id_rs2_data, id_imm, id_pc (DATA_WIDTH each): operand values. id_alu_src_a (1): 0 selects rs1, 1 selects pc. id_alu_src_b (1): 0 selects rs2, 1 selects imm. id_alu_ctrl (4): {func7[5],func3}. id_reg_write, id_mem_read (1 each).
REQ-005 Control input flush, input, 1 bit: kill the instruction entering EX this cycle.
REQ-006 Forwarding inputs SHALL be mem_rd (5), mem_reg_write (1) and mem_result (DATA_WIDTH) from the EX/MEM stage, and wb_rd (5), wb_reg_write (1) and wb_result (DATA_WIDTH) from the MEM/WB stage.
REQ-007 Outputs to the ALU SHALL be ALUop1 (DATA_WIDTH), ALUop2 (DATA_WIDTH) and ALUctrl (4).
REQ-008 Outputs downstream SHALL be ex_valid (1), ex_rd (5), ex_reg_write (1), ex_mem_read (1), ex_store_data (DATA_WIDTH: forwarded rs2) and ex_pc (DATA_WIDTH).
REQ-009 Outputs upstream SHALL be stall_id (1): decode holds its slot. stall_count (32): number of load-use stall cycles.

Function
REQ-010 The EX register SHALL hold valid, rs1, rs2, rd, use flags, rs1/rs2 data, imm, pc, src selects, alu_ctrl, reg_write and mem_read.
REQ-011 The load-use hazard signal SHALL be asserted when all of the following hold: ex_valid, ex_mem_read, ex_rd != 0, id_valid, and (id_use_rs1 with id_rs1 == ex_rd, or id_use_rs2 with id_rs2 == ex_rd).
REQ-012 stall_id SHALL equal hazard & ~flush, combinationally, in the same cycle.
REQ-013 Update priority per edge SHALL be: rst, then flush, then hazard, then normal load.
REQ-014 On flush or hazard, the EX register SHALL load a bubble: valid=0, reg_write=0, mem_read=0, and all other fields 0.
REQ-015 On a normal edge, the EX register SHALL load all id_* fields, with valid=id_valid; if id_valid=0, reg_write and mem_read SHALL be loaded as 0.
REQ-016 Latency SHALL be one cycle from decode inputs to ALU outputs; throughput SHALL be one instruction per cycle absent hazards.
REQ-017 rs1 forwarding SHALL select, in priority order: mem_result if mem_reg_write, mem_rd != 0 and mem_rd == ex_rs1; else wb_result if wb_reg_write, wb_rd != 0 and wb_rd == ex_rs1; else the registered rs1 data.
REQ-018 rs2 forwarding SHALL follow the same priority as REQ-017 using ex_rs2; its result SHALL drive ex_store_data.
REQ-019 Register x0 SHALL never be forwarded; the registered value SHALL be used.
REQ-020 ALUop1 SHALL equal ex_pc when src_a=1, otherwise forwarded rs1; ALUop2 SHALL equal ex_imm when src_b=1, otherwise forwarded rs2.
REQ-021 When ex_valid=0, ALUop1, ALUop2, ALUctrl and ex_store_data SHALL all be driven 0.
REQ-022 ex_rd, ex_reg_write, ex_mem_read and ex_pc SHALL be driven directly from the register.
REQ-023 stall_count SHALL increment by 1 on each edge where stall_id=1, and SHALL saturate at 0xFFFFFFFF without wrapping.
REQ-024 A hazard SHALL last exactly one cycle, because the next edge inserts a bubble and clears the ex_mem_read match.
REQ-025 Simultaneous flush and hazard SHALL produce a bubble, stall_id=0 and no stall_count increment.
REQ-026 A single-cycle match on both MEM and WB forwarding sources SHALL take the MEM value.

Reset
REQ-027 When rst=1 at an edge, the EX register SHALL clear to all zeros (ex_valid=0) and stall_count SHALL clear to 0.
REQ-028 Reset SHALL take priority over flush and stall.
REQ-029 Reset applied mid-hazard SHALL discard the in-flight load, so that stall_id=0 in the cycle after reset.
REQ-030 After reset, all outputs SHALL be 0.

Verification
REQ-031 Basic ADD: id_rs1_data=5, id_rs2_data=7, src_a=0, src_b=0, alu_ctrl=0000, id_valid=1 -> next cycle ALUop1=5, ALUop2=7, ALUctrl=0000, ex_valid=1.
REQ-032 Forward priority: ex_rs1=3 with mem_rd=3/mem_result=0xAA and wb_rd=3/wb_result=0xBB, both reg_write=1 -> ALUop1=0xAA; with mem_reg_write=0 -> ALUop1=0xBB; with rd=0 everywhere -> registered value.
REQ-033 Load-use: EX holds a load with rd=4, and ID has use_rs2=1, rs2=4 -> stall_id=1 for one cycle; next edge ex_valid=0 and stall_count=1; the following edge loads the dependent instruction with stall_id=0.
REQ-034 Flush with hazard: conditions of REQ-033 plus flush=1 -> stall_id=0, next cycle ex_valid=0, stall_count unchanged.
REQ-035 Immediate/pc select: src_a=1, pc=0x100, src_b=1, imm=0xFFFFFFFC -> ALUop1=0x100, ALUop2=0xFFFFFFFC.
REQ-036 Reset: rst=1 mid-stream with stall_count=0xFFFFFFFF -> next cycle all outputs 0; a prior saturation check confirms no wrap.
